// File: rtl/execute_pkg.sv
// Shared decode/execute constants: datapath widths, ALU opcodes and operand-source selects.
// Both pipeline stages import this so the encodings cannot drift apart.
package execute_pkg;

   localparam int WORD     = 32;
   localparam int REG_SIZE = 5;

   // ALU operation codes; 11-15 are unused and produce 0.
   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   // Operand-source selects: which values feed ALU inputs A and B.
   localparam logic [1:0] SRC_REG_REG = 2'd0;  // A=rdata1, B=rdata2
   localparam logic [1:0] SRC_REG_IMM = 2'd1;  // A=rdata1, B=imm
   localparam logic [1:0] SRC_PC_IMM  = 2'd2;  // A=pc,     B=imm
   localparam logic [1:0] SRC_PC_4    = 2'd3;  // A=pc,     B=4 (link address)

   localparam int SHAMT_W = 5;

endpackage

// File: rtl/execute_if.sv
// E-to-M stage boundary bundle: decode drives the E side, execute drives the M side.
interface execute_if
   import execute_pkg::*;
#(
   parameter int WORD     = execute_pkg::WORD,
   parameter int REG_SIZE = execute_pkg::REG_SIZE
);

   logic [WORD-1:0]     rdata1E;
   logic [WORD-1:0]     rdata2E;
   logic [WORD-1:0]     immE;
   logic [WORD-1:0]     pcE;
   logic [REG_SIZE-1:0] writeRegE;
   logic [3:0]          ALUControlE;
   logic [1:0]          ALUSrcE;
   logic                regWriteE;
   logic                memWriteE;
   logic                mem2regE;
   logic                branchE;

   logic [WORD-1:0]     writeDataM;
   logic [REG_SIZE-1:0] writeRegM;
   logic [WORD-1:0]     ALUResultM;
   logic [WORD-1:0]     pcM;
   logic                regWriteM;
   logic                memWriteM;
   logic                mem2regM;
   logic                branchM;
   logic                zeroM;

   // Upstream stage: presents an instruction, observes the memory-stage result.
   modport master (
      output rdata1E, rdata2E, immE, pcE, writeRegE, ALUControlE, ALUSrcE,
             regWriteE, memWriteE, mem2regE, branchE,
      input  writeDataM, writeRegM, ALUResultM, pcM,
             regWriteM, memWriteM, mem2regM, branchM, zeroM
   );

   // Execute stage itself.
   modport slave (
      input  rdata1E, rdata2E, immE, pcE, writeRegE, ALUControlE, ALUSrcE,
             regWriteE, memWriteE, mem2regE, branchE,
      output writeDataM, writeRegM, ALUResultM, pcM,
             regWriteM, memWriteM, mem2regM, branchM, zeroM
   );

endinterface

// File: rtl/execute_alu.sv
// Purely combinational ALU: result of op applied to A and B, plus an all-zero flag.
module alu
   import execute_pkg::*;
#(
   parameter int WORD = execute_pkg::WORD
) (
   input  logic [WORD-1:0] A,
   input  logic [WORD-1:0] B,
   input  logic [3:0]      op,
   output logic [WORD-1:0] result,
   output logic            zero
);

   logic [SHAMT_W-1:0] w_shamt;
   logic               w_lt_signed;
   logic               w_lt_unsigned;

   assign w_shamt       = B[SHAMT_W-1:0];
   assign w_lt_signed   = $signed(A) < $signed(B);
   assign w_lt_unsigned = A < B;

   always_comb begin
      // NOTE: the default assignment before the case keeps every path driven, so no latch is inferred.
      result = '0;
      case (op)
         ALU_ADD:   result = A + B;
         ALU_SUB:   result = A - B;
         ALU_SLL:   result = A << w_shamt;
         ALU_SLT:   result = {{(WORD-1){1'b0}}, w_lt_signed};
         ALU_SLTU:  result = {{(WORD-1){1'b0}}, w_lt_unsigned};
         ALU_XOR:   result = A ^ B;
         ALU_SRL:   result = A >> w_shamt;
         ALU_SRA:   result = $unsigned($signed(A) >>> w_shamt);
         ALU_OR:    result = A | B;
         ALU_AND:   result = A & B;
         ALU_PASSB: result = B;
         default:   result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/execute.sv
// Execute pipeline stage: operand select, ALU, branch-target adder and the E->M register.
// Every instruction is accepted each cycle; results appear exactly one edge later.
module execute
   import execute_pkg::*;
#(
   parameter int WORD     = execute_pkg::WORD,
   parameter int REG_SIZE = execute_pkg::REG_SIZE
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [WORD-1:0]     rdata1E,
   input  logic [WORD-1:0]     rdata2E,
   input  logic [WORD-1:0]     immE,
   input  logic [WORD-1:0]     pcE,
   input  logic [REG_SIZE-1:0] writeRegE,
   input  logic [3:0]          ALUControlE,
   input  logic [1:0]          ALUSrcE,
   input  logic                regWriteE,
   input  logic                memWriteE,
   input  logic                mem2regE,
   input  logic                branchE,
   output logic [WORD-1:0]     writeDataM,
   output logic [REG_SIZE-1:0] writeRegM,
   output logic [WORD-1:0]     ALUResultM,
   output logic [WORD-1:0]     pcM,
   output logic                regWriteM,
   output logic                memWriteM,
   output logic                mem2regM,
   output logic                branchM,
   output logic                zeroM
);

   logic [WORD-1:0] w_a;
   logic [WORD-1:0] w_b;
   logic [WORD-1:0] w_alu_result;
   logic            w_alu_zero;
   logic [WORD-1:0] w_target;

   logic [WORD-1:0]     r_write_data;
   logic [REG_SIZE-1:0] r_write_reg;
   logic [WORD-1:0]     r_alu_result;
   logic [WORD-1:0]     r_pc_target;
   logic                r_reg_write;
   logic                r_mem_write;
   logic                r_mem2reg;
   logic                r_branch;
   logic                r_zero;

   always_comb begin
      w_a = rdata1E;
      w_b = rdata2E;
      case (ALUSrcE)
         SRC_REG_REG: begin w_a = rdata1E; w_b = rdata2E;     end
         SRC_REG_IMM: begin w_a = rdata1E; w_b = immE;        end
         SRC_PC_IMM:  begin w_a = pcE;     w_b = immE;        end
         SRC_PC_4:    begin w_a = pcE;     w_b = WORD'(4);    end
         default:     begin w_a = rdata1E; w_b = rdata2E;     end
      endcase
   end

   alu #(.WORD(WORD)) u_alu (
      .A      (w_a),
      .B      (w_b),
      .op     (ALUControlE),
      .result (w_alu_result),
      .zero   (w_alu_zero)
   );

   // Branch target is independent of operand select so a compare and a target share one cycle.
   assign w_target = pcE + immE;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_write_data <= '0;
         r_write_reg  <= '0;
         r_alu_result <= '0;
         r_pc_target  <= '0;
         r_reg_write  <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem2reg    <= 1'b0;
         r_branch     <= 1'b0;
         r_zero       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every M field samples the same pre-edge E values.
         r_write_data <= rdata2E;
         r_write_reg  <= writeRegE;
         r_alu_result <= w_alu_result;
         r_pc_target  <= w_target;
         r_reg_write  <= regWriteE;
         r_mem_write  <= memWriteE;
         r_mem2reg    <= mem2regE;
         r_branch     <= branchE;
         r_zero       <= w_alu_zero;
      end
   end

   assign writeDataM = r_write_data;
   assign writeRegM  = r_write_reg;
   assign ALUResultM = r_alu_result;
   assign pcM        = r_pc_target;
   assign regWriteM  = r_reg_write;
   assign memWriteM  = r_mem_write;
   assign mem2regM   = r_mem2reg;
   assign branchM    = r_branch;
   assign zeroM      = r_zero;

endmodule

// File: tb/tb_execute.sv
// Directed-vector bench for the execute stage with hand-computed expected M values.
module tb_execute;
   import execute_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   execute_if #(.WORD(32), .REG_SIZE(5)) bus ();

   execute #(.WORD(32), .REG_SIZE(5)) dut (
      .clk         (clk),
      .reset       (rst_n),
      .rdata1E     (bus.rdata1E),
      .rdata2E     (bus.rdata2E),
      .immE        (bus.immE),
      .pcE         (bus.pcE),
      .writeRegE   (bus.writeRegE),
      .ALUControlE (bus.ALUControlE),
      .ALUSrcE     (bus.ALUSrcE),
      .regWriteE   (bus.regWriteE),
      .memWriteE   (bus.memWriteE),
      .mem2regE    (bus.mem2regE),
      .branchE     (bus.branchE),
      .writeDataM  (bus.writeDataM),
      .writeRegM   (bus.writeRegM),
      .ALUResultM  (bus.ALUResultM),
      .pcM         (bus.pcM),
      .regWriteM   (bus.regWriteM),
      .memWriteM   (bus.memWriteM),
      .mem2regM    (bus.mem2regM),
      .branchM     (bus.branchM),
      .zeroM       (bus.zeroM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_errors++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic drive(input logic [1:0] src, input logic [3:0] op,
                        input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] imm, input logic [31:0] pc,
                        input logic [4:0] wr, input logic [3:0] flags);
      bus.ALUSrcE     = src;
      bus.ALUControlE = op;
      bus.rdata1E     = rd1;
      bus.rdata2E     = rd2;
      bus.immE        = imm;
      bus.pcE         = pc;
      bus.writeRegE   = wr;
      {bus.regWriteE, bus.memWriteE, bus.mem2regE, bus.branchE} = flags;
   endtask

   // Drive at the falling edge, let one rising edge capture, sample 1 time unit later.
   task automatic issue(input logic [1:0] src, input logic [3:0] op,
                        input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] imm, input logic [31:0] pc,
                        input logic [4:0] wr, input logic [3:0] flags);
      @(negedge clk);
      drive(src, op, rd1, rd2, imm, pc, wr, flags);
      @(posedge clk);
      #1;
   endtask

   task automatic check_result(input string tag, input logic [31:0] res, input logic z);
      check({tag, ".alu"},  bus.ALUResultM, res);
      check({tag, ".zero"}, 32'(bus.zeroM), 32'(z));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".writeDataM"}, bus.writeDataM, 32'h0);
      check({tag, ".writeRegM"},  32'(bus.writeRegM), 32'h0);
      check({tag, ".ALUResultM"}, bus.ALUResultM, 32'h0);
      check({tag, ".pcM"},        bus.pcM, 32'h0);
      check({tag, ".flags"},
            32'({bus.regWriteM, bus.memWriteM, bus.mem2regM, bus.branchM, bus.zeroM}), 32'h0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      drive(SRC_REG_REG, ALU_ADD, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 4'b0000);
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // ADD through register operands
      issue(SRC_REG_REG, ALU_ADD, 32'd5, 32'd7, 32'h0, 32'h0, 5'd3, 4'b1000);
      check_result("add", 32'd12, 1'b0);
      check("add.regWriteM", 32'(bus.regWriteM), 32'd1);
      check("add.writeRegM", 32'(bus.writeRegM), 32'd3);
      check("add.writeDataM", bus.writeDataM, 32'd7);

      // Branch-equal: SUB of equal operands, target wraps below pc
      issue(SRC_REG_REG, ALU_SUB, 32'h1234, 32'h1234, 32'hFFFF_FFF8, 32'h100, 5'd0, 4'b0001);
      check_result("beq", 32'h0, 1'b1);
      check("beq.branchM", 32'(bus.branchM), 32'd1);
      check("beq.pcM", bus.pcM, 32'hF8);
      check("beq.regWriteM", 32'(bus.regWriteM), 32'd0);

      // Store: address from imm, data from rdata2 not operand B
      issue(SRC_REG_IMM, ALU_ADD, 32'h1000, 32'hDEAD_BEEF, 32'd8, 32'h0, 5'd0, 4'b0100);
      check_result("store", 32'h1008, 1'b0);
      check("store.writeDataM", bus.writeDataM, 32'hDEAD_BEEF);
      check("store.memWriteM", 32'(bus.memWriteM), 32'd1);

      // Load flag pass-through
      issue(SRC_REG_IMM, ALU_ADD, 32'h2000, 32'h0, 32'hFFFF_FFFC, 32'h0, 5'd9, 4'b1010);
      check_result("load", 32'h1FFC, 1'b0);
      check("load.mem2regM", 32'(bus.mem2regM), 32'd1);
      check("load.writeRegM", 32'(bus.writeRegM), 32'd9);

      // Shifts and compares
      issue(SRC_REG_REG, ALU_SRA, 32'h8000_0000, 32'd4, 32'h0, 32'h0, 5'd0, 4'b0000);
      check_result("sra", 32'hF800_0000, 1'b0);
      issue(SRC_REG_REG, ALU_SRL, 32'h8000_0000, 32'd4, 32'h0, 32'h0, 5'd0, 4'b0000);
      check_result("srl", 32'h0800_0000, 1'b0);
      issue(SRC_REG_REG, ALU_SLL, 32'h1, 32'h0000_003F, 32'h0, 32'h0, 5'd0, 4'b0000);
      check_result("sll_shamt_low5", 32'h8000_0000, 1'b0);
      issue(SRC_REG_REG, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 5'd0, 4'b0000);
      check_result("slt", 32'd1, 1'b0);
      issue(SRC_REG_REG, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 5'd0, 4'b0000);
      check_result("sltu", 32'd0, 1'b1);

      // Bitwise operations
      issue(SRC_REG_REG, ALU_XOR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 32'h0, 5'd0, 4'b0000);
      check_result("xor", 32'h0000_0FF0, 1'b0);
      issue(SRC_REG_REG, ALU_OR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 32'h0, 5'd0, 4'b0000);
      check_result("or", 32'h0000_FFF0, 1'b0);
      issue(SRC_REG_REG, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 32'h0, 5'd0, 4'b0000);
      check_result("and", 32'h0000_F000, 1'b0);

      // Wrap-around add, undefined opcode
      issue(SRC_REG_REG, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 5'd0, 4'b0000);
      check_result("add_wrap", 32'h0, 1'b1);
      issue(SRC_REG_REG, 4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'h0, 5'd0, 4'b0000);
      check_result("op12", 32'h0, 1'b1);

      // pc-relative (auipc-style), link and PASSB
      issue(SRC_PC_IMM, ALU_ADD, 32'h0, 32'h0, 32'h10, 32'h40, 5'd0, 4'b0000);
      check_result("pc_imm", 32'h50, 1'b0);
      check("pc_imm.pcM", bus.pcM, 32'h50);
      issue(SRC_PC_4, ALU_ADD, 32'h0, 32'h0, 32'h0, 32'h20, 5'd1, 4'b1000);
      check_result("link", 32'h24, 1'b0);
      issue(SRC_REG_IMM, ALU_PASSB, 32'h5555_5555, 32'h0, 32'hABCD_E000, 32'h0, 5'd0, 4'b0000);
      check_result("passb", 32'hABCD_E000, 1'b0);

      // Mid-operation reset: outputs clear immediately, in-flight instruction is dropped
      issue(SRC_REG_REG, ALU_ADD, 32'd1, 32'd2, 32'h4, 32'h8, 5'd7, 4'b1111);
      check("pre_rst.alu", bus.ALUResultM, 32'd3);
      @(negedge clk);
      drive(SRC_REG_REG, ALU_ADD, 32'd5, 32'd7, 32'h0, 32'h0, 5'd3, 4'b1000);
      #1;
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_async");
      @(posedge clk);
      #1;
      check_all_zero("rst_held");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_all_zero("rst_released");
      @(posedge clk);
      #1;
      check_result("post_rst", 32'd12, 1'b0);
      check("post_rst.writeRegM", 32'(bus.writeRegM), 32'd3);
      check("post_rst.regWriteM", 32'(bus.regWriteM), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have parameter WORD, default 32, the datapath width in bits.
REQ-002 SHALL have parameter REG_SIZE, default 5, the register-index width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-005 SHALL have port rdata1E, input, WORD bits: register operand 1.
REQ-006 SHALL have port rdata2E, input, WORD bits: register operand 2 and store data.
REQ-007 SHALL have port immE, input, WORD bits: sign-extended immediate.
REQ-008 SHALL have port pcE, input, WORD bits: PC of the instruction.
REQ-009 SHALL have port writeRegE, input, REG_SIZE bits: destination register index.
REQ-010 SHALL have port ALUControlE, input, 4 bits: ALU operation code.
REQ-011 SHALL have port ALUSrcE, input, 2 bits: operand-source select.
REQ-012 SHALL have ports regWriteE, memWriteE, mem2regE and branchE, each input, 1 bit: control flags.
REQ-013 SHALL have port writeDataM, output, WORD bits: registered rdata2E.
REQ-014 SHALL have port writeRegM, output, REG_SIZE bits: registered writeRegE.
REQ-015 SHALL have port ALUResultM, output, WORD bits: registered ALU result.
REQ-016 SHALL have port pcM, output, WORD bits: registered branch target pcE+immE.
REQ-017 SHALL have ports regWriteM, memWriteM, mem2regM and branchM, each output, 1 bit: registered control flags.
REQ-018 SHALL have port zeroM, output, 1 bit: registered flag, 1 when the ALU result is 0.

Function
REQ-019 SHALL select operands combinationally from ALUSrcE: 0 gives A=rdata1E, B=rdata2E; 1 gives A=rdata1E, B=immE; 2 gives A=pcE, B=immE; 3 gives A=pcE, B=4.
REQ-020 SHALL compute the ALU result combinationally from ALUControlE, A and B as follows:
  - 0 ADD: A+B; 1 SUB: A-B; 2 SLL: A<<B[4:0]; 3 SLT: signed A<B gives 1, else 0.
  - 4 SLTU: unsigned A<B gives 1, else 0; 5 XOR; 6 SRL: logical shift by B[4:0]; 7 SRA: arithmetic shift by B[4:0].
  - 8 OR; 9 AND; 10 PASSB: B.
  - Codes 11-15: result 0.
REQ-021 SHALL perform all arithmetic modulo 2^WORD, with overflow and carry discarded and no exception.
REQ-022 SHALL compute the branch target as pcE+immE (wrap-around), independent of ALUSrcE and ALUControlE.
REQ-023 SHALL compute zero as 1 exactly when the full ALU result equals 0.
REQ-024 SHALL capture all M outputs in one pipeline register on the rising clk edge, giving latency of exactly 1 cycle from E inputs to M outputs.
REQ-025 SHALL pass flags and writeRegE through unchanged, regardless of the ALU operation.
REQ-026 SHALL have no stall, flush or handshake; a new instruction is accepted every cycle.
REQ-027 SHALL register writeDataM from rdata2E, never from the selected operand B.

Reset
REQ-028 SHALL, while reset is low, asynchronously force every M output to 0, including pcM, zeroM and all flags.
REQ-029 SHALL, when reset is asserted mid-operation, discard the in-flight instruction; the first capture after release occurs at the next rising edge.

Structure
REQ-030 SHALL take WORD, REG_SIZE, the ALU opcode constants (0-10) and the ALUSrc constants (0-3) from a shared package used by the decode and execute stages.
REQ-031 SHALL instantiate one combinational sub-module alu (inputs A, B, op; outputs result, zero); operand muxing, target adder and pipeline register stay in execute.

Verification
REQ-032 SHALL check ADD: ALUSrcE=0, rdata1E=5, rdata2E=7, ALUControlE=0, regWriteE=1, writeRegE=3 -> next edge: ALUResultM=12, zeroM=0, regWriteM=1, writeRegM=3, writeDataM=7.
REQ-033 SHALL check branch-equal: rdata1E=rdata2E=0x1234, SUB, branchE=1, pcE=0x100, immE=0xFFFFFFF8 -> ALUResultM=0, zeroM=1, branchM=1, pcM=0xF8.
REQ-034 SHALL check store: ALUSrcE=1, rdata1E=0x1000, immE=8, rdata2E=0xDEADBEEF, ADD, memWriteE=1 -> ALUResultM=0x1008, writeDataM=0xDEADBEEF, memWriteM=1.
REQ-035 SHALL check shifts and compares: A=0x80000000, B=4 -> SRA gives 0xF8000000 and SRL gives 0x08000000; A=0xFFFFFFFF, B=1 -> SLT gives 1 and SLTU gives 0.
REQ-036 SHALL check link and PASSB: ALUSrcE=3, pcE=0x20, ADD -> ALUResultM=0x24; ALUSrcE=1, immE=0xABCDE000, PASSB -> ALUResultM=0xABCDE000.
REQ-037 SHALL check reset: assert reset low between clock edges after valid traffic -> all M outputs 0 immediately; release -> the first instruction appears one edge later.
